// File: rtl/lockstep_diverge_monitor.sv
// Two-copy lockstep monitor: sequences core reset, then compares masked observation
// channels from copies A and B inside a fixed cycle window and records the first divergence.
module lockstep_diverge_monitor #(
  parameter int unsigned NUM_CH       = 8,
  parameter int unsigned CH_W         = 32,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned INIT_CYCLE   = 2,
  parameter int unsigned CHECK_START  = 3,
  parameter int unsigned CHECK_END    = 14,
  localparam int unsigned CH_IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [NUM_CH-1:0]        valid_a,
  input  logic [NUM_CH-1:0]        valid_b,
  input  logic [NUM_CH*CH_W-1:0]   data_a,
  input  logic [NUM_CH*CH_W-1:0]   data_b,
  output logic                     core_reset,
  output logic                     init_eq,
  output logic                     checking,
  output logic                     diverge,
  output logic [NUM_CH-1:0]        diverge_ch,
  output logic [CNT_W-1:0]         first_cyc,
  output logic [CH_IDX_W-1:0]      first_ch,
  output logic                     done
);

  typedef enum logic [1:0] {
    ST_SEQ  = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cyc_q, cyc_d;
  logic [NUM_CH-1:0]   div_q, div_d;
  logic [CNT_W-1:0]    first_cyc_q, first_cyc_d;
  logic [CH_IDX_W-1:0] first_ch_q, first_ch_d;

  logic [NUM_CH-1:0]   mis;
  logic [CH_IDX_W-1:0] low_idx;
  logic                in_window;

  // Per-channel mismatch; data only matters when both copies are valid.
  always_comb begin
    mis = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      mis[i] = ch_mask[i] & ((valid_a[i] ^ valid_b[i]) |
               (valid_a[i] & valid_b[i] &
                (data_a[i*CH_W +: CH_W] != data_b[i*CH_W +: CH_W])));
    end
  end

  // Lowest mismatching index wins; scan downward so the last hit is the lowest.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mis[i]) low_idx = CH_IDX_W'(i);
    end
  end

  assign in_window = (state_q == ST_RUN) &&
                     (cyc_q >= CNT_W'(CHECK_START)) && (cyc_q <= CNT_W'(CHECK_END));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_SEQ;
      cyc_q       <= '0;
      div_q       <= '0;
      first_cyc_q <= '0;
      first_ch_q  <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      div_q       <= div_d;
      first_cyc_q <= first_cyc_d;
      first_ch_q  <= first_ch_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cyc_d       = (cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1);
    div_d       = div_q;
    first_cyc_d = first_cyc_q;
    first_ch_d  = first_ch_q;

    case (state_q)
      ST_SEQ:  if (cyc_q == CNT_W'(RESET_CYCLES - 1)) state_d = ST_RUN;
      ST_RUN:  if (cyc_q == CNT_W'(CHECK_END)) state_d = ST_DONE;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_SEQ;
    endcase

    if (in_window && (|mis)) begin
      div_d = div_q | mis;
      if (!(|div_q)) begin
        first_cyc_d = cyc_q;
        first_ch_d  = low_idx;
      end
    end

    // Re-arm overrides everything, including a mismatch seen this cycle.
    if (clear) begin
      state_d     = ST_SEQ;
      cyc_d       = '0;
      div_d       = '0;
      first_cyc_d = '0;
      first_ch_d  = '0;
    end
  end

  assign core_reset = (state_q == ST_SEQ);
  assign init_eq    = (cyc_q == CNT_W'(INIT_CYCLE)) && (state_q != ST_DONE);
  assign checking   = in_window;
  assign diverge    = |div_q;
  assign diverge_ch = div_q;
  assign first_cyc  = first_cyc_q;
  assign first_ch   = first_ch_q;
  assign done       = (state_q == ST_DONE);

endmodule

// File: doc/lockstep_diverge_monitor.md
# lockstep_diverge_monitor

Synthesizable two-copy lockstep monitor for self-composed Sodor core checks. It sequences core reset, then compares NUM_CH observation channels from copy A and copy B inside a programmable cycle window. It records sticky per-channel divergence, the first divergent cycle and channel, and a done flag. It sits in the security-verification top between the two core instances, so both BMC and simulation benches share one divergence definition.

## Interface
- NUM_CH, 8: number of compared channels.
- CH_W, 32: data width per channel.
- CNT_W, 8: cycle-counter width.
- RESET_CYCLES, 2: cycles `core_reset` is held high after monitor reset release; ≥1.
- INIT_CYCLE, 2: cycle at which `init_eq` pulses; RESET_CYCLES ≤ INIT_CYCLE.
- CHECK_START, 3: first compared cycle; ≥ INIT_CYCLE.
- CHECK_END, 14: last compared cycle; CHECK_START ≤ CHECK_END < 2^CNT_W−1.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low monitor reset.
- clear  in  1  synchronous re-arm; returns to SEQ and clears all results.
- ch_mask  in  NUM_CH  1 = channel compared; 0 = ignored.
- valid_a / valid_b  in  NUM_CH each  per-channel valid from copy A / B.
- data_a / data_b  in  NUM_CH*CH_W each  channel i at bits [i*CH_W +: CH_W].
- core_reset  out  1  active-high reset driven to both cores.
- init_eq  out  1  one-cycle pulse; the bench constrains initial architectural state equal here.
- checking  out  1  high while the current cycle lies in the compare window.
- diverge  out  1  sticky OR of diverge_ch.
- diverge_ch  out  NUM_CH  sticky per-channel divergence.
- first_cyc  out  CNT_W  cycle of the first divergence; 0 if none.
- first_ch  out  $clog2(NUM_CH) (min 1)  channel of the first divergence.
- done  out  1  high from the cycle after CHECK_END until clear or reset.

## Operation
- Cycle counter `cyc`: 0 at reset or clear, increments by 1 every cycle, saturates at 2^CNT_W−1.
- States:
  - SEQ: `core_reset`=1. Moves to RUN when `cyc`==RESET_CYCLES−1.
  - RUN: `core_reset`=0. Moves to DONE after the edge that samples `cyc`==CHECK_END.
  - DONE: terminal; the counter keeps running but nothing is compared.
- `init_eq`=1 exactly when `cyc`==INIT_CYCLE and state≠DONE.
- `checking`=1 when state==RUN and CHECK_START ≤ `cyc` ≤ CHECK_END.
- Channel i mismatches when `ch_mask`[i] and (`valid_a`[i] XOR `valid_b`[i], or both valid and data differ). Data is ignored unless both copies are valid.
- On a sampling edge with `checking`=1, each mismatching channel sets `diverge_ch`[i].
- First event only, i.e. while `diverge`=0:
  - `first_cyc` ← `cyc`.
  - `first_ch` ← lowest mismatching index (lowest index wins on simultaneous mismatches).
- Later mismatches only add bits to `diverge_ch`; they never change `first_cyc` or `first_ch`.
- `clear` has priority over all other updates and takes effect in any state, including mid-window.

## Timing
- Reset values (reset=0, asynchronous): `cyc`=0, state=SEQ, `core_reset`=1, and every other output 0.
- All outputs are registered or decoded from registered state only. There are no combinational paths from channel inputs to outputs.
- A mismatch presented during cycle k (with `cyc`=k in the window) appears on `diverge`/`diverge_ch` in cycle k+1, with `first_cyc`=k.
- Default sequence: `core_reset` high for cycles 0–1, `init_eq` at cycle 2, compare cycles 3–14, `done` rises at cycle 15.
- `clear` asserted in cycle k: in cycle k+1, `cyc`=0, state=SEQ, `core_reset`=1 and all results are 0. A mismatch in cycle k is discarded.
- Reset released mid-run restarts at cycle 0 identically to power-up.
- Saturated `cyc` does not re-enter the window because CHECK_END < max.

## Test plan
- Identical inputs on all channels, mask all-ones, defaults -> `core_reset` high for cycles 0–1, `init_eq` only at cycle 2, `done` at 15, `diverge`=0, `first_cyc`=0.
- valid_a[2]=1, valid_b[2]=0 at cycle 5 only -> cycle 6: `diverge_ch`=8'b0000_0100, `first_cyc`=5, `first_ch`=2; values hold through `done`.
- Both valid on ch 1 and ch 6 with different data at cycle 7, then ch 0 mismatch at cycle 9 -> `first_ch`=1, `first_cyc`=7, final `diverge_ch`=8'b0100_0011.
- Data mismatch with both valids 0, with ch_mask bit 0, at cycle 2, and at cycle 15 -> no divergence recorded in any case.
- Mismatch at cycle 4 then `clear` at cycle 8 -> cycle 9: all outputs 0 and `core_reset`=1; a clean rerun ends with `diverge`=0.
- reset pulled low at cycle 10 for one cycle with an existing divergence -> all outputs reset asynchronously; the sequence restarts at cycle 0.
